// File: rtl/logic_fabric_pkg.sv
// Shared definitions for the logic-fabric config loader: FSM state encoding,
// frame beat indices, control-word field positions and the legal range of
// the compare-op select.
package logic_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_COMMIT    = 2'd2,
    ST_ERR_DRAIN = 2'd3
  } cfgState_e;

  // Beat position inside a 4-beat configuration frame.
  localparam logic [1:0] IDX_MASK_A = 2'd0;
  localparam logic [1:0] IDX_MASK_B = 2'd1;
  localparam logic [1:0] IDX_CONST  = 2'd2;
  localparam logic [1:0] IDX_CTRL   = 2'd3;

  // Control word layout: bit0 = operand-B select, bits 3:1 = compare-op select.
  localparam int CTRL_OPB_BIT  = 0;
  localparam int CTRL_RMUX_LSB = 1;
  localparam int CTRL_RMUX_MSB = 3;

  // Highest compare-op encoding the comparator implements.
  localparam logic [2:0] RESULT_MUX_MAX = 3'd5;

  function automatic logic rmuxOutOfRange(input logic [2:0] rm);
    return (rm > RESULT_MUX_MAX);
  endfunction

endpackage

// File: rtl/logic_block_cfg_readback.sv
// Readback streamer: on a request it snapshots the four active config words
// and streams them out in frame order over a valid/ready handshake. Requests
// arriving while a stream is in progress are ignored. Only instantiated when
// the loader is built with CFG_READBACK_EN.
module logic_block_cfg_readback
  import logic_fabric_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] wordMaskA,
  input  logic [WORD_W-1:0] wordMaskB,
  input  logic [WORD_W-1:0] wordConst,
  input  logic [WORD_W-1:0] wordCtrl,
  input  logic              rd_req,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
);

  logic [WORD_W-1:0] snap [4];
  logic [1:0]        rdPtr;
  logic              streaming;
  logic              startStream;

  assign startStream = rd_req & ~streaming;

  // Stream control: start on a request when idle, advance on each accepted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streaming <= 1'b0;
      rdPtr     <= IDX_MASK_A;
    end else if (startStream) begin
      streaming <= 1'b1;
      rdPtr     <= IDX_MASK_A;
    end else if (streaming && rd_ready) begin
      if (rdPtr == IDX_CTRL) begin
        streaming <= 1'b0;
      end
      rdPtr <= rdPtr + 2'd1;
    end
  end

  // Snapshot the active words at request time so a later commit cannot tear the stream.
  always_ff @(posedge clk) begin
    if (startStream) begin
      snap[IDX_MASK_A] <= wordMaskA;
      snap[IDX_MASK_B] <= wordMaskB;
      snap[IDX_CONST]  <= wordConst;
      snap[IDX_CTRL]   <= wordCtrl;
    end
  end

  assign rd_valid = streaming;
  assign rd_data  = snap[rdPtr];

endmodule

// File: rtl/logic_block_cfg_loader.sv
// Configuration loader for one logic block comparator. Collects 4-beat frames
// (mask_a, mask_b, constant, control) into shadow registers and promotes them
// to the active outputs atomically, one cycle after the final beat, so the
// comparator never sees a partial frame. Malformed frames raise a sticky
// frame_err that a later good commit clears.
// Optional feature macro: CFG_READBACK_EN adds a readback stream port.
module logic_block_cfg_loader
  import logic_fabric_pkg::*;
#(
  parameter int WORD_W        = 32,
  parameter bit RESET_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] cfg_in_data,
  input  logic              cfg_in_valid,
  input  logic              cfg_in_last,
  output logic              cfg_in_ready,
  input  logic              cfg_abort,
  input  logic              prev_invalid_in,
  output logic [WORD_W-1:0] mask_a,
  output logic [WORD_W-1:0] mask_b,
  output logic [WORD_W-1:0] constant,
  output logic              op_b_mux,
  output logic [2:0]        result_mux,
  output logic              cfg_invalid,
  output logic              commit,
  output logic              frame_err
`ifdef CFG_READBACK_EN
  ,
  input  logic              rd_req,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready
`endif
);

  cfgState_e         state;
  logic [1:0]        beatIdx;
  logic              loaded;

  logic [WORD_W-1:0] shMaskA;
  logic [WORD_W-1:0] shMaskB;
  logic [WORD_W-1:0] shConst;
  logic              shOpB;
  logic [2:0]        shRmux;

  logic              beatXfer;
  logic              abortHit;
  logic              shadowWe;

  // The loader only refuses beats in the single commit cycle.
  assign cfg_in_ready = (state != ST_COMMIT);
  assign beatXfer     = cfg_in_valid & cfg_in_ready;

  // Abort only matters while a frame is being collected or drained.
  assign abortHit = cfg_abort & ((state == ST_LOAD) | (state == ST_ERR_DRAIN));

  // Shadow capture happens only for beats belonging to a frame in progress.
  assign shadowWe = beatXfer & ~abortHit & ((state == ST_IDLE) | (state == ST_LOAD));

  // Frame sequencing, framing-error tracking and the commit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      beatIdx   <= IDX_MASK_A;
      frame_err <= 1'b0;
      commit    <= 1'b0;
      loaded    <= ~RESET_INVALID;
    end else begin
      commit <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (beatXfer) begin
            if (cfg_in_last) begin
              frame_err <= 1'b1;
              beatIdx   <= IDX_MASK_A;
            end else begin
              state   <= ST_LOAD;
              beatIdx <= IDX_MASK_B;
            end
          end
        end
        ST_LOAD: begin
          if (cfg_abort) begin
            state   <= ST_IDLE;
            beatIdx <= IDX_MASK_A;
          end else if (beatXfer) begin
            if (beatIdx == IDX_CTRL) begin
              beatIdx <= IDX_MASK_A;
              if (cfg_in_last) begin
                state <= ST_COMMIT;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_ERR_DRAIN;
              end
            end else if (cfg_in_last) begin
              frame_err <= 1'b1;
              state     <= ST_IDLE;
              beatIdx   <= IDX_MASK_A;
            end else begin
              beatIdx <= beatIdx + 2'd1;
            end
          end
        end
        ST_COMMIT: begin
          state     <= ST_IDLE;
          commit    <= 1'b1;
          loaded    <= 1'b1;
          frame_err <= 1'b0;
        end
        ST_ERR_DRAIN: begin
          if (cfg_abort || (beatXfer && cfg_in_last)) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shadow registers: written beat by beat, only ever read at commit time.
  always_ff @(posedge clk) begin
    if (shadowWe) begin
      unique case (beatIdx)
        IDX_MASK_A: shMaskA <= cfg_in_data;
        IDX_MASK_B: shMaskB <= cfg_in_data;
        IDX_CONST:  shConst <= cfg_in_data;
        IDX_CTRL: begin
          shOpB  <= cfg_in_data[CTRL_OPB_BIT];
          shRmux <= cfg_in_data[CTRL_RMUX_MSB:CTRL_RMUX_LSB];
        end
      endcase
    end
  end

  // Active config: all fields move together from the shadow in the commit cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_a     <= '0;
      mask_b     <= '0;
      constant   <= '0;
      op_b_mux   <= 1'b0;
      result_mux <= 3'd0;
    end else if (state == ST_COMMIT) begin
      mask_a     <= shMaskA;
      mask_b     <= shMaskB;
      constant   <= shConst;
      op_b_mux   <= shOpB;
      result_mux <= shRmux;
    end
  end

  // Invalid whenever upstream is invalid, the op select is unimplemented, or nothing was loaded yet.
  assign cfg_invalid = prev_invalid_in | rmuxOutOfRange(result_mux) | ~loaded;

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] ctrlWord;

  assign ctrlWord = {{(WORD_W-4){1'b0}}, result_mux, op_b_mux};

  logic_block_cfg_readback #(
    .WORD_W (WORD_W)
  ) uReadback (
    .clk       (clk),
    .rst_n     (rst_n),
    .wordMaskA (mask_a),
    .wordMaskB (mask_b),
    .wordConst (constant),
    .wordCtrl  (ctrlWord),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready)
  );
`endif

endmodule

// File: tb/tb_logic_block_cfg_loader.sv
// Bench for logic_block_cfg_loader: table of per-cycle vectors with expected
// outputs, then hand-written reset-mid-frame and (optionally) readback sequences.
module tb_logic_block_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic [31:0] cfg_in_data;
  logic        cfg_in_valid;
  logic        cfg_in_last;
  logic        cfg_in_ready;
  logic        cfg_abort;
  logic        prev_invalid_in;
  logic [31:0] mask_a;
  logic [31:0] mask_b;
  logic [31:0] constant;
  logic        op_b_mux;
  logic [2:0]  result_mux;
  logic        cfg_invalid;
  logic        commit;
  logic        frame_err;
`ifdef CFG_READBACK_EN
  logic        rd_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
`endif

  logic_block_cfg_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_in_data     (cfg_in_data),
    .cfg_in_valid    (cfg_in_valid),
    .cfg_in_last     (cfg_in_last),
    .cfg_in_ready    (cfg_in_ready),
    .cfg_abort       (cfg_abort),
    .prev_invalid_in (prev_invalid_in),
    .mask_a          (mask_a),
    .mask_b          (mask_b),
    .constant        (constant),
    .op_b_mux        (op_b_mux),
    .result_mux      (result_mux),
    .cfg_invalid     (cfg_invalid),
    .commit          (commit),
    .frame_err       (frame_err)
`ifdef CFG_READBACK_EN
    ,
    .rd_req          (rd_req),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready)
`endif
  );

  typedef struct packed {
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] cn;
    logic        ob;
    logic [2:0]  rm;
  } cfgv_t;

  typedef struct {
    logic        v, l, a, p;
    logic [31:0] d;
    logic        rdy, cmt, fe, inv;
    cfgv_t       c;
  } vec_t;

  vec_t vecs[$];
  int   nChecks = 0;
  int   nPass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic cfgv_t mkc(input logic [31:0] ma, mb, cn, input logic ob, input logic [2:0] rm);
    cfgv_t c;
    c.ma = ma; c.mb = mb; c.cn = cn; c.ob = ob; c.rm = rm;
    return c;
  endfunction

  task automatic addRow(input logic v, l, a, p, input logic [31:0] d,
                        input logic rdy, cmt, fe, inv, input cfgv_t c);
    vec_t r;
    r.v = v; r.l = l; r.a = a; r.p = p; r.d = d;
    r.rdy = rdy; r.cmt = cmt; r.fe = fe; r.inv = inv; r.c = c;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic [31:0] d, input logic l);
    cfg_in_valid = 1'b1;
    cfg_in_data  = d;
    cfg_in_last  = l;
    tick();
    cfg_in_valid = 1'b0;
    cfg_in_last  = 1'b0;
  endtask

  task automatic waitCommit(input string name);
    int k = 0;
    while (!commit && k < 4) begin
      tick();
      k++;
    end
    chk(name, 128'(commit), 128'(1'b1));
  endtask

  function automatic logic [127:0] outsNow();
    return 128'({cfg_in_ready, commit, frame_err, cfg_invalid,
                 mask_a, mask_b, constant, op_b_mux, result_mux});
  endfunction

  initial begin
    cfgv_t z, o1, o2, o3, o4, o5, o6, o7;
    z  = mkc(32'h0, 32'h0, 32'h0, 1'b0, 3'd0);
    o1 = mkc(32'hFF00FF00, 32'h0000FFFF, 32'h12345678, 1'b1, 3'd2);
    o2 = mkc(32'hAAAA0000, 32'h0000BBBB, 32'hCAFEF00D, 1'b1, 3'd6);
    o3 = mkc(32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 3'd2);
    o4 = mkc(32'h66666666, 32'h77777777, 32'h88888888, 1'b1, 3'd1);
    o5 = mkc(32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0, 1'b0, 3'd0);
    o6 = mkc(32'hE1E1E1E1, 32'hE2E2E2E2, 32'hE3E3E3E3, 1'b1, 3'd3);
    o7 = mkc(32'h01010101, 32'h02020202, 32'h03030303, 1'b0, 3'd1);

    // Basic frame with a valid gap; commit one cycle after the last beat.
    addRow(1,0,0,0,32'hFF00FF00, 1,0,0,1, z);
    addRow(1,0,0,0,32'h0000FFFF, 1,0,0,1, z);
    addRow(0,0,0,0,32'hDEADBEEF, 1,0,0,1, z);
    addRow(1,0,0,0,32'h12345678, 1,0,0,1, z);
    addRow(1,1,0,0,32'h00000005, 0,0,0,1, z);
    addRow(0,0,0,0,32'h0,        1,1,0,0, o1);
    addRow(0,0,0,0,32'h0,        1,0,0,0, o1);
    // Out-of-range op select; a beat offered during commit must be refused.
    addRow(1,0,0,0,32'hAAAA0000, 1,0,0,0, o1);
    addRow(1,0,0,0,32'h0000BBBB, 1,0,0,0, o1);
    addRow(1,0,0,0,32'hCAFEF00D, 1,0,0,0, o1);
    addRow(1,1,0,0,32'h0000000D, 0,0,0,0, o1);
    addRow(1,0,0,0,32'h0BADBAD0, 1,1,0,1, o2);
    // Valid frame with upstream invalid.
    addRow(1,0,0,1,32'h11111111, 1,0,0,1, o2);
    addRow(1,0,0,1,32'h22222222, 1,0,0,1, o2);
    addRow(1,0,0,1,32'h33333333, 1,0,0,1, o2);
    addRow(1,1,0,1,32'h00000004, 0,0,0,1, o2);
    addRow(0,0,0,1,32'h0,        1,1,0,1, o3);
    addRow(0,0,0,0,32'h0,        1,0,0,0, o3);
    // Early last on beat 2, then a good frame clears the error.
    addRow(1,0,0,0,32'h44444444, 1,0,0,0, o3);
    addRow(1,1,0,0,32'h55555555, 1,0,1,0, o3);
    addRow(0,0,0,0,32'h0,        1,0,1,0, o3);
    addRow(1,0,0,0,32'h66666666, 1,0,1,0, o3);
    addRow(1,0,0,0,32'h77777777, 1,0,1,0, o3);
    addRow(1,0,0,0,32'h88888888, 1,0,1,0, o3);
    addRow(1,1,0,0,32'h00000003, 0,0,1,0, o3);
    addRow(0,0,0,0,32'h0,        1,1,0,0, o4);
    // Missing last on beat 4 -> drain until last, then a good frame.
    addRow(1,0,0,0,32'h99999999, 1,0,0,0, o4);
    addRow(1,0,0,0,32'h9A9A9A9A, 1,0,0,0, o4);
    addRow(1,0,0,0,32'h9B9B9B9B, 1,0,0,0, o4);
    addRow(1,0,0,0,32'h0000000E, 1,0,1,0, o4);
    addRow(1,0,0,0,32'h0000000F, 1,0,1,0, o4);
    addRow(1,1,0,0,32'h0000000F, 1,0,1,0, o4);
    addRow(1,0,0,0,32'hA0A0A0A0, 1,0,1,0, o4);
    addRow(1,0,0,0,32'hB0B0B0B0, 1,0,1,0, o4);
    addRow(1,0,0,0,32'hC0C0C0C0, 1,0,1,0, o4);
    addRow(1,1,0,0,32'h00000000, 0,0,1,0, o4);
    addRow(0,0,0,0,32'h0,        1,1,0,0, o5);
    // Abort with beat 3 wins; abort in IDLE and in COMMIT is ignored.
    addRow(1,0,0,0,32'hD1D1D1D1, 1,0,0,0, o5);
    addRow(1,0,0,0,32'hD2D2D2D2, 1,0,0,0, o5);
    addRow(1,0,1,0,32'hD3D3D3D3, 1,0,0,0, o5);
    addRow(1,0,1,0,32'hE1E1E1E1, 1,0,0,0, o5);
    addRow(1,0,0,0,32'hE2E2E2E2, 1,0,0,0, o5);
    addRow(1,0,0,0,32'hE3E3E3E3, 1,0,0,0, o5);
    addRow(1,1,0,0,32'h00000007, 0,0,0,0, o5);
    addRow(0,0,1,0,32'h0,        1,1,0,0, o6);
    // Abort exits the drain state without touching frame_err.
    addRow(1,0,0,0,32'hF1F1F1F1, 1,0,0,0, o6);
    addRow(1,0,0,0,32'hF2F2F2F2, 1,0,0,0, o6);
    addRow(1,0,0,0,32'hF3F3F3F3, 1,0,0,0, o6);
    addRow(1,0,0,0,32'h00000001, 1,0,1,0, o6);
    addRow(0,0,1,0,32'h0,        1,0,1,0, o6);
    addRow(1,0,0,0,32'h01010101, 1,0,1,0, o6);
    addRow(1,0,0,0,32'h02020202, 1,0,1,0, o6);
    addRow(1,0,0,0,32'h03030303, 1,0,1,0, o6);
    addRow(1,1,0,0,32'h00000002, 0,0,1,0, o6);
    addRow(0,0,0,0,32'h0,        1,1,0,0, o7);

    rst_n = 1'b0;
    cfg_in_data = '0; cfg_in_valid = 1'b0; cfg_in_last = 1'b0;
    cfg_abort = 1'b0; prev_invalid_in = 1'b0;
`ifdef CFG_READBACK_EN
    rd_req = 1'b0; rd_ready = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("reset_state", outsNow(), 128'({4'b1001, z}));
    tick();

    foreach (vecs[i]) begin
      cfg_in_valid    = vecs[i].v;
      cfg_in_last     = vecs[i].l;
      cfg_abort       = vecs[i].a;
      prev_invalid_in = vecs[i].p;
      cfg_in_data     = vecs[i].d;
      tick();
      chk($sformatf("row%0d", i), outsNow(),
          128'({vecs[i].rdy, vecs[i].cmt, vecs[i].fe, vecs[i].inv, vecs[i].c}));
    end
    cfg_in_valid = 1'b0; cfg_in_last = 1'b0; cfg_abort = 1'b0; prev_invalid_in = 1'b0;
    tick();

`ifdef CFG_READBACK_EN
    begin
      logic [31:0] rdExp [4];
      rdExp[0] = 32'hFF00FF00; rdExp[1] = 32'h0000FFFF;
      rdExp[2] = 32'h12345678; rdExp[3] = 32'h00000005;
      sendBeat(32'hFF00FF00, 1'b0);
      sendBeat(32'h0000FFFF, 1'b0);
      sendBeat(32'h12345678, 1'b0);
      sendBeat(32'h00000005, 1'b1);
      waitCommit("rb_commit");
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      for (int w = 0; w < 4; w++) begin
        rd_ready = 1'b0;
        for (int s = 0; s < 2; s++) begin
          chk($sformatf("rb_stall_w%0d_s%0d", w, s), 128'({rd_valid, rd_data}), 128'({1'b1, rdExp[w]}));
          tick();
        end
        rd_ready = 1'b1;
        chk($sformatf("rb_word%0d", w), 128'({rd_valid, rd_data}), 128'({1'b1, rdExp[w]}));
        tick();
      end
      rd_ready = 1'b0;
      chk("rb_done", 128'(rd_valid), 128'(1'b0));
    end
`endif

    // Random valid activity, then reset lands in the middle of a frame.
    for (int c = 0; c < 7; c++) begin
      cfg_in_valid = 1'($urandom_range(0, 1));
      cfg_in_data  = $urandom;
      cfg_in_last  = 1'b0;
      tick();
    end
    cfg_in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("reset_mid_frame", 128'({commit, frame_err, cfg_invalid, mask_a, mask_b, constant, op_b_mux, result_mux}),
           128'({3'b001, z}));
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("post_reset_ready_inv", 128'({cfg_in_ready, cfg_invalid}), 128'(2'b11));
    tick();
    sendBeat(32'hCAFE0001, 1'b0);
    sendBeat(32'hCAFE0002, 1'b0);
    sendBeat(32'hCAFE0003, 1'b0);
    sendBeat(32'h00000009, 1'b1);
    chk("inv_before_first_commit", 128'({cfg_invalid, commit, mask_a}), 128'({2'b10, 32'h0}));
    waitCommit("post_reset_commit");
    chk("post_reset_cfg", 128'({cfg_invalid, frame_err, mask_a, mask_b, constant, op_b_mux, result_mux}),
        128'({2'b00, mkc(32'hCAFE0001, 32'hCAFE0002, 32'hCAFE0003, 1'b1, 3'd4)}));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
